// File: rtl/cache_ctrl.sv
// cache_ctrl: blocking direct-mapped write-back/write-allocate cache controller with hit/miss counters
module cache_ctrl #(
    parameter int LINE_SIZE = 4,
    parameter int CACHE_SIZE = 1024,
    localparam int SET_W = $clog2(CACHE_SIZE / LINE_SIZE),
    localparam int OFF_W = $clog2(LINE_SIZE),
    localparam int TAG_W = 32 - SET_W - OFF_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic             req_write,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic [31:0]      c_addr,
    input  logic             c_hit,
    input  logic             c_dirty,
    input  logic [31:0]      c_data,
    input  logic [TAG_W-1:0] c_victim_tag,
    output logic [31:0]      c_wdata,
    output logic             c_wvalid,
    output logic             c_waccess,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [31:0]      mem_req_addr,
    output logic             mem_req_write,
    output logic [31:0]      mem_req_wdata,
    input  logic             mem_resp_valid,
    input  logic [31:0]      mem_resp_rdata,
    output logic [31:0]      hit_cnt,
    output logic [31:0]      miss_cnt
);
    typedef enum logic [2:0] {IDLE, LOOKUP, WB, RD_REQ, RD_WAIT} state_t;
    state_t           r_state;
    logic [31:0]      r_addr, r_wdata, r_vdata, r_hit_cnt, r_miss_cnt;
    logic             r_write;
    logic [TAG_W-1:0] r_vtag;
    logic [SET_W-1:0] w_set;
    logic             w_lookup, w_wb_hs, w_rd_done, w_wr_now;
    // Outputs are combinational on state so a hit answers the cycle after acceptance; rst masks them all but c_addr.
    always_comb begin
        w_set         = r_addr[OFF_W +: SET_W];
        w_lookup      = r_state == LOOKUP;
        w_wb_hs       = r_state == WB && mem_req_ready;
        w_rd_done     = r_state == RD_WAIT && mem_resp_valid;
        w_wr_now      = r_write && ((w_lookup && (c_hit || !c_dirty)) || w_wb_hs);
        req_ready     = !rst && r_state == IDLE;
        c_addr        = r_state == IDLE ? req_addr : r_addr;
        resp_valid    = !rst && (w_wr_now || w_rd_done || (w_lookup && c_hit));
        resp_rdata    = rst ? '0 : w_rd_done ? mem_resp_rdata : (w_lookup && c_hit && !r_write) ? c_data : '0;
        c_wvalid      = !rst && (w_wr_now || w_rd_done);
        c_waccess     = !rst && w_wr_now;
        c_wdata       = rst ? '0 : w_rd_done ? mem_resp_rdata : w_wr_now ? r_wdata : '0;
        mem_req_valid = !rst && (r_state == WB || r_state == RD_REQ);
        mem_req_write = !rst && r_state == WB;
        mem_req_addr  = rst ? '0 : r_state == WB ? {r_vtag, w_set, {OFF_W{1'b0}}} :
                        r_state == RD_REQ ? {r_addr[31:OFF_W], {OFF_W{1'b0}}} : '0;
        mem_req_wdata = mem_req_write ? r_vdata : '0;
        hit_cnt       = rst ? '0 : r_hit_cnt;
        miss_cnt      = rst ? '0 : r_miss_cnt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_vtag     <= '0;
            r_vdata    <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_addr  <= req_addr;
                    r_write <= req_write;
                    r_wdata <= req_wdata;
                    r_state <= LOOKUP;
                end
                LOOKUP: begin
                    if (c_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
                    else begin
                        r_miss_cnt <= r_miss_cnt + 32'd1;
                        r_vtag     <= c_victim_tag;
                        r_vdata    <= c_data;
                    end
                    r_state <= c_hit ? IDLE : c_dirty ? WB : r_write ? IDLE : RD_REQ;
                end
                WB:      if (mem_req_ready) r_state <= r_write ? IDLE : RD_REQ;
                RD_REQ:  if (mem_req_ready) r_state <= RD_WAIT;
                RD_WAIT: if (mem_resp_valid) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: random and directed requests against a word-level memory/cache reference model
module tb_cache_ctrl;
    logic clk = 1'b0, rst;
    logic req_valid, req_ready, req_write, resp_valid;
    logic [31:0] req_addr, req_wdata, resp_rdata, c_addr, c_data, c_wdata;
    logic c_hit, c_dirty, c_wvalid, c_waccess;
    logic [21:0] c_victim_tag;
    logic mem_req_valid, mem_req_ready, mem_req_write, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata, hit_cnt, miss_cnt;
    int errors = 0, checks = 0;

    cache_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .c_addr(c_addr), .c_hit(c_hit), .c_dirty(c_dirty), .c_data(c_data), .c_victim_tag(c_victim_tag),
        .c_wdata(c_wdata), .c_wvalid(c_wvalid), .c_waccess(c_waccess), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_req_write(mem_req_write),
        .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // direct-mapped array with 1-cycle synchronous read
    logic [21:0] a_tag [256];
    logic [31:0] a_data [256];
    logic a_dirty [256];
    logic a_val [256] = '{default: 1'b0};
    int arr_writes = 0;
    always @(posedge clk) begin
        c_hit        <= a_val[c_addr[9:2]] && a_tag[c_addr[9:2]] == c_addr[31:10];
        c_dirty      <= a_val[c_addr[9:2]] && a_dirty[c_addr[9:2]];
        c_data       <= a_data[c_addr[9:2]];
        c_victim_tag <= a_tag[c_addr[9:2]];
        if (c_wvalid) begin
            a_val[c_addr[9:2]]   <= 1'b1;
            a_tag[c_addr[9:2]]   <= c_addr[31:10];
            a_data[c_addr[9:2]]  <= c_wdata;
            a_dirty[c_addr[9:2]] <= c_waccess;
            arr_writes           <= arr_writes + 1;
        end
    end

    logic [31:0] bmem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic m_val [256] = '{default: 1'b0};
    logic m_dirty [256];
    logic [21:0] m_tag [256];
    int n_hit = 0, n_miss = 0;
    logic e_hit, e_wb, e_fetch;
    logic [31:0] e_wb_addr, e_wb_data, e_rdata;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : init_val(a);
    endfunction
    function automatic logic [31:0] ref_val(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        bmem[a] = d;
        ref_mem[a] = d;
    endtask

    // architectural view: a read returns the last value written to the word
    task automatic predict(input logic [31:0] a, input logic wr, input logic [31:0] wd);
        logic [7:0] s;
        s = a[9:2];
        e_hit = m_val[s] && m_tag[s] == a[31:10];
        e_wb = !e_hit && m_val[s] && m_dirty[s];
        e_wb_addr = {m_tag[s], s, 2'b00};
        e_wb_data = ref_val(e_wb_addr);
        e_fetch = !e_hit && !wr;
        e_rdata = wr ? 32'h0 : ref_val({a[31:2], 2'b00});
        if (wr) begin
            ref_mem[{a[31:2], 2'b00}] = wd;
            m_dirty[s] = 1'b1;
        end else if (!e_hit) m_dirty[s] = 1'b0;
        m_val[s] = 1'b1;
        m_tag[s] = a[31:10];
        if (e_hit) n_hit++; else n_miss++;
    endtask

    logic o_ready, o_got, o_wv, o_wa, o_wb_stable, o_resp_hs;
    logic [31:0] o_rdata, o_cwdata, o_wb_addr, o_wb_data, o_rd_addr;
    int o_lat, o_wb_n, o_rd_n, o_wb_wait;

    // issue one request (called in IDLE) and act as memory until the response
    task automatic do_req(input logic [31:0] a, input logic wr, input logic [31:0] wd, input int rdy_lat, input int rsp_lat);
        int wait_n, rsp_n;
        logic pend, wb_seen;
        logic [31:0] paddr;
        {o_got, o_wv, o_wa, o_resp_hs} = '0;
        o_wb_stable = 1'b1;
        {o_rdata, o_cwdata, o_wb_addr, o_wb_data, o_rd_addr} = '0;
        o_lat = 0; o_wb_n = 0; o_rd_n = 0; o_wb_wait = 0;
        wait_n = 0; rsp_n = 0; pend = 1'b0; wb_seen = 1'b0; paddr = '0;
        #1 o_ready = req_ready;
        req_valid = 1'b1; req_addr = a; req_write = wr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_write = 1'($urandom_range(0, 1)); req_wdata = $urandom;
        for (int n = 1; n <= 80 && !o_got; n++) begin
            mem_req_ready = mem_req_valid && wait_n >= rdy_lat;
            mem_resp_valid = pend && rsp_n >= rsp_lat;
            mem_resp_rdata = mem_resp_valid ? mem_val(paddr) : $urandom;
            #1;
            if (mem_resp_valid) pend = 1'b0; else if (pend) rsp_n++;
            if (mem_req_valid && mem_req_write) begin
                if (!wb_seen) begin
                    o_wb_addr = mem_req_addr; o_wb_data = mem_req_wdata; wb_seen = 1'b1;
                end else if (mem_req_addr !== o_wb_addr || mem_req_wdata !== o_wb_data) o_wb_stable = 1'b0;
                if (mem_req_ready) begin
                    o_wb_n++; bmem[mem_req_addr] = mem_req_wdata; o_resp_hs = resp_valid;
                end else o_wb_wait++;
            end else if (mem_req_valid && mem_req_ready) begin
                o_rd_n++; o_rd_addr = mem_req_addr; paddr = mem_req_addr; pend = 1'b1; rsp_n = 0;
            end
            wait_n = (mem_req_valid && !mem_req_ready) ? wait_n + 1 : 0;
            if (resp_valid) begin
                o_got = 1'b1; o_lat = n; o_rdata = resp_rdata; o_wv = c_wvalid; o_wa = c_waccess; o_cwdata = c_wdata;
            end
            @(negedge clk);
        end
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_addr = 32'h1004;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
        checks++; if ({resp_valid, c_wvalid, c_waccess, mem_req_valid, mem_req_write} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes got=%b exp=00000", {resp_valid, c_wvalid, c_waccess, mem_req_valid, mem_req_write}); end
        checks++; if ({resp_rdata, mem_req_addr, mem_req_wdata, c_wdata} !== 128'h0) begin
            errors++; $display("FAIL reset_data got=%h exp=0", {resp_rdata, mem_req_addr, mem_req_wdata, c_wdata}); end
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", req_ready); end
        checks++; if (hit_cnt !== 0 || miss_cnt !== 0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
        n_hit = 0; n_miss = 0;
    endtask

    task automatic test_read_miss();
        poke(32'h1004, 32'hDEAD_BEEF);
        predict(32'h1004, 1'b0, 32'h0);
        do_req(32'h1004, 1'b0, 32'h0, 1, 2);
        checks++; if (o_got !== 1'b1) begin errors++; $display("FAIL rmiss_resp got=%b exp=1", o_got); end
        checks++; if (o_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rmiss_rdata got=%h exp=deadbeef", o_rdata); end
        checks++; if (o_rd_n !== 1 || o_rd_addr !== 32'h1004) begin errors++; $display("FAIL rmiss_fetch got=%0d@%h exp=1@00001004", o_rd_n, o_rd_addr); end
        checks++; if (o_wb_n !== 0) begin errors++; $display("FAIL rmiss_wb got=%0d exp=0", o_wb_n); end
        checks++; if ({o_wv, o_wa} !== 2'b10 || o_cwdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rmiss_fill got=%b%b %h exp=10 deadbeef", o_wv, o_wa, o_cwdata); end
        checks++; if (miss_cnt !== 1 || hit_cnt !== 0) begin errors++; $display("FAIL rmiss_cnt got=%0d/%0d exp=0/1", hit_cnt, miss_cnt); end
    endtask

    task automatic test_read_hit();
        predict(32'h1004, 1'b0, 32'h0);
        do_req(32'h1004, 1'b0, 32'h0, 0, 0);
        checks++; if (o_lat !== 1) begin errors++; $display("FAIL rhit_latency got=%0d exp=1", o_lat); end
        checks++; if (o_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rhit_rdata got=%h exp=deadbeef", o_rdata); end
        checks++; if (o_rd_n + o_wb_n !== 0 || o_wv !== 1'b0) begin errors++; $display("FAIL rhit_traffic got=%0d/%b exp=0/0", o_rd_n + o_wb_n, o_wv); end
        checks++; if (hit_cnt !== 1) begin errors++; $display("FAIL rhit_cnt got=%0d exp=1", hit_cnt); end
    endtask

    task automatic test_write_evict();
        predict(32'h1004, 1'b1, 32'h1234_5678);
        do_req(32'h1004, 1'b1, 32'h1234_5678, 0, 0);
        checks++; if (o_lat !== 1 || o_rdata !== 32'h0) begin errors++; $display("FAIL whit_resp got=%0d/%h exp=1/0", o_lat, o_rdata); end
        checks++; if ({o_wv, o_wa} !== 2'b11 || o_cwdata !== 32'h1234_5678) begin
            errors++; $display("FAIL whit_write got=%b%b %h exp=11 12345678", o_wv, o_wa, o_cwdata); end
        checks++; if (hit_cnt !== 2) begin errors++; $display("FAIL whit_cnt got=%0d exp=2", hit_cnt); end
        predict(32'h0004_1004, 1'b0, 32'h0);
        do_req(32'h0004_1004, 1'b0, 32'h0, 2, 1);
        checks++; if (o_wb_n !== 1 || o_wb_addr !== 32'h1004 || o_wb_data !== 32'h1234_5678) begin
            errors++; $display("FAIL evict_wb got=%0d %h %h exp=1 00001004 12345678", o_wb_n, o_wb_addr, o_wb_data); end
        checks++; if (o_rd_n !== 1 || o_rd_addr !== 32'h0004_1004) begin errors++; $display("FAIL evict_fetch got=%0d@%h exp=1@00041004", o_rd_n, o_rd_addr); end
        checks++; if (o_rdata !== e_rdata) begin errors++; $display("FAIL evict_rdata got=%h exp=%h", o_rdata, e_rdata); end
        checks++; if (miss_cnt !== 2) begin errors++; $display("FAIL evict_cnt got=%0d exp=2", miss_cnt); end
    endtask

    task automatic test_write_miss_stall();
        predict(32'h0004_1004, 1'b1, 32'hA5A5_0001);
        do_req(32'h0004_1004, 1'b1, 32'hA5A5_0001, 0, 0);
        predict(32'h0008_1004, 1'b1, 32'hCAFE_F00D);
        do_req(32'h0008_1004, 1'b1, 32'hCAFE_F00D, 5, 0);
        checks++; if (o_wb_wait !== 5 || o_wb_stable !== 1'b1) begin errors++; $display("FAIL stall_hold got=%0d/%b exp=5/1", o_wb_wait, o_wb_stable); end
        checks++; if (o_wb_addr !== 32'h0004_1004 || o_wb_data !== 32'hA5A5_0001) begin
            errors++; $display("FAIL stall_wb got=%h %h exp=00041004 a5a50001", o_wb_addr, o_wb_data); end
        checks++; if (o_resp_hs !== 1'b1 || {o_wv, o_wa} !== 2'b11) begin errors++; $display("FAIL stall_resp got=%b %b%b exp=1 11", o_resp_hs, o_wv, o_wa); end
        checks++; if (o_rd_n !== 0) begin errors++; $display("FAIL stall_nofetch got=%0d exp=0", o_rd_n); end
        checks++; if (hit_cnt !== n_hit || miss_cnt !== n_miss) begin errors++; $display("FAIL stall_cnt got=%0d/%0d exp=%0d/%0d", hit_cnt, miss_cnt, n_hit, n_miss); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            predict(32'h0008_1004, 1'b0, 32'h0);
            do_req(32'h0008_1004, 1'b0, 32'h0, 0, 0);
            checks++; if (o_ready !== 1'b1 || o_lat !== 1) begin errors++; $display("FAIL b2b_%0d got=%b/%0d exp=1/1", i, o_ready, o_lat); end
            checks++; if (o_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_rdata_%0d got=%h exp=cafef00d", i, o_rdata); end
        end
    endtask

    task automatic test_stray_resp();
        logic [31:0] h, m;
        int w;
        h = hit_cnt; m = miss_cnt; w = arr_writes;
        req_valid = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5555_AAAA;
        #1;
        checks++; if ({resp_valid, c_wvalid, mem_req_valid, req_ready} !== 4'b0001) begin
            errors++; $display("FAIL stray_outputs got=%b exp=0001", {resp_valid, c_wvalid, mem_req_valid, req_ready}); end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        checks++; if (hit_cnt !== h || miss_cnt !== m || arr_writes !== w || req_ready !== 1'b1) begin
            errors++; $display("FAIL stray_state got=%0d/%0d/%0d exp=%0d/%0d/%0d", hit_cnt, miss_cnt, arr_writes, h, m, w); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a, wd;
            logic wr;
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            predict(a, wr, wd);
            do_req(a, wr, wd, $urandom_range(0, 3), $urandom_range(0, 3));
            checks++; if (o_got !== 1'b1 || o_ready !== 1'b1) begin errors++; $display("FAIL rnd_handshake a=%h got=%b/%b exp=1/1", a, o_ready, o_got); end
            checks++; if (o_rdata !== e_rdata) begin errors++; $display("FAIL rnd_rdata a=%h got=%h exp=%h", a, o_rdata, e_rdata); end
            checks++; if (o_wb_n !== int'(e_wb) || (e_wb && (o_wb_addr !== e_wb_addr || o_wb_data !== e_wb_data))) begin
                errors++; $display("FAIL rnd_wb a=%h got=%0d %h %h exp=%0d %h %h", a, o_wb_n, o_wb_addr, o_wb_data, e_wb, e_wb_addr, e_wb_data); end
            checks++; if (o_rd_n !== int'(e_fetch) || (e_fetch && o_rd_addr !== {a[31:2], 2'b00})) begin
                errors++; $display("FAIL rnd_fetch a=%h got=%0d@%h exp=%0d", a, o_rd_n, o_rd_addr, e_fetch); end
            checks++; if ({o_wv, o_wa} !== {!(e_hit && !wr), wr} || (e_hit && o_lat !== 1)) begin
                errors++; $display("FAIL rnd_array a=%h got=%b%b lat=%0d exp=%b%b", a, o_wv, o_wa, o_lat, !(e_hit && !wr), wr); end
        end
        checks++; if (hit_cnt !== n_hit || miss_cnt !== n_miss) begin errors++; $display("FAIL rnd_cnt got=%0d/%0d exp=%0d/%0d", hit_cnt, miss_cnt, n_hit, n_miss); end
    endtask

    task automatic test_reset_abort();
        int w0;
        w0 = arr_writes;
        req_valid = 1'b1; req_addr = 32'h2200; req_write = 1'b0; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_req_addr !== 32'h2200) begin
            errors++; $display("FAIL abort_rdreq got=%b%b %h exp=10 00002200", mem_req_valid, mem_req_write, mem_req_addr); end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; rst = 1'b1;
        #1;
        checks++; if ({mem_req_valid, resp_valid, c_wvalid, req_ready} !== 4'b0 || hit_cnt !== 0 || miss_cnt !== 0) begin
            errors++; $display("FAIL abort_in_rst got=%b %0d/%0d exp=0000 0/0", {mem_req_valid, resp_valid, c_wvalid, req_ready}, hit_cnt, miss_cnt); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0BAD_0BAD;
        #1;
        checks++; if (resp_valid !== 1'b0 || c_wvalid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL abort_late_resp got=%b%b%b exp=001", resp_valid, c_wvalid, req_ready); end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        checks++; if (arr_writes !== w0 || hit_cnt !== 0 || miss_cnt !== 0) begin
            errors++; $display("FAIL abort_state got=%0d %0d/%0d exp=%0d 0/0", arr_writes, hit_cnt, miss_cnt, w0); end
        n_hit = 0; n_miss = 0;
        predict(32'h2200, 1'b0, 32'h0);
        do_req(32'h2200, 1'b0, 32'h0, 1, 1);
        checks++; if (o_rdata !== e_rdata || miss_cnt !== 1) begin errors++; $display("FAIL abort_recover got=%h/%0d exp=%h/1", o_rdata, miss_cnt, e_rdata); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_evict();
        test_write_miss_stall();
        test_back_to_back();
        test_stray_resp();
        test_random();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter LINE_SIZE, default 4, line size in bytes (one 32-bit word per line).
REQ-002 SHALL have parameter CACHE_SIZE, default 1024, capacity in bytes; SET_W=$clog2(CACHE_SIZE/LINE_SIZE), OFF_W=$clog2(LINE_SIZE), TAG_W=32-SET_W-OFF_W.
REQ-003 SHALL have one clock and a synchronous, active-high reset, with ports:
  clk  in  1  clock, all state on rising edge
  rst  in  1  synchronous active-high reset
REQ-004 SHALL have requester ports:
  req_valid in 1, req_ready out 1, req_addr in 32, req_write in 1, req_wdata in 32
  resp_valid out 1 (single-cycle pulse, no backpressure), resp_rdata out 32
REQ-005 SHALL have cache-array ports, driving a direct-mapped array with 1-cycle synchronous read:
  c_addr out 32, c_hit in 1, c_dirty in 1, c_data in 32, c_victim_tag in TAG_W
  c_wdata out 32, c_wvalid out 1 (line write strobe), c_waccess out 1 (dirty bit written with line)
REQ-006 SHALL have memory ports: mem_req_valid out 1, mem_req_ready in 1, mem_req_addr out 32, mem_req_write out 1, mem_req_wdata out 32, mem_resp_valid in 1, mem_resp_rdata in 32.
REQ-007 SHALL have hit_cnt out 32 and miss_cnt out 32, performance counters.

Function
REQ-008 SHALL implement FSM states IDLE, LOOKUP, WB, RD_REQ, RD_WAIT; exactly one request in flight.
REQ-009 IDLE: req_ready=1, c_addr=req_addr (combinational); on req_valid latch addr/write/wdata, go LOOKUP; all other states req_ready=0, c_addr=latched addr.
REQ-010 LOOKUP read hit: resp_valid=1, resp_rdata=c_data, hit_cnt+1, -> IDLE (response 1 cycle after acceptance).
REQ-011 LOOKUP write hit: c_wvalid=1, c_waccess=1, c_wdata=latched wdata, resp_valid=1, resp_rdata=0, hit_cnt+1, -> IDLE.
REQ-012 LOOKUP miss: miss_cnt+1; latch c_victim_tag and c_data; if c_dirty -> WB; else write -> perform write as REQ-011 (no fetch, line = word), -> IDLE; else read -> RD_REQ.
REQ-013 WB: mem_req_valid=1, mem_req_write=1, mem_req_addr={victim_tag, set, OFF_W'0}, mem_req_wdata=victim data; held stable until mem_req_ready; write complete on handshake (no response expected).
REQ-014 WB handshake cycle: if write -> c_wvalid=1, c_waccess=1, resp_valid=1, -> IDLE; if read -> RD_REQ.
REQ-015 RD_REQ: mem_req_valid=1, mem_req_write=0, mem_req_addr={addr[31:OFF_W], OFF_W'0}; on mem_req_ready -> RD_WAIT.
REQ-016 RD_WAIT: on mem_resp_valid -> c_wvalid=1, c_waccess=0, c_wdata=mem_resp_rdata, resp_valid=1, resp_rdata=mem_resp_rdata, -> IDLE.
REQ-017 mem_resp_valid outside RD_WAIT SHALL be ignored; mem_req_ready outside WB/RD_REQ ignored.
REQ-018 c_wvalid, resp_valid, mem_req_valid SHALL be 0 in every state/condition not listed above.
REQ-019 Counters SHALL wrap modulo 2^32; each request counts exactly once, in LOOKUP.
REQ-020 Back-to-back: a new request MAY be accepted in the IDLE cycle directly after resp_valid.

Reset
REQ-021 rst SHALL force IDLE and clear hit_cnt, miss_cnt and latched request/victim registers to 0.
REQ-022 During rst all outputs except c_addr SHALL be 0 (req_ready=0 while rst=1); req_ready=1 the first cycle after rst deasserts.
REQ-023 rst mid-WB/RD_REQ/RD_WAIT SHALL abort: mem_req_valid drops next cycle, no array write, no resp_valid; a late mem_resp_valid is ignored.

Verification
REQ-024 Read miss clean, addr 0x0000_1004, memory returns 0xDEAD_BEEF -> RD_REQ addr 0x0000_1004, resp_rdata 0xDEAD_BEEF, array written dirty=0, miss_cnt=1.
REQ-025 Re-read 0x0000_1004 -> resp_valid exactly 1 cycle after acceptance, rdata 0xDEAD_BEEF, no mem request, hit_cnt=1.
REQ-026 Write 0x0000_1004 = 0x1234_5678 (hit), then read 0x0004_1004 (same set, dirty) -> WB write addr 0x0000_1004 data 0x1234_5678, then read 0x0004_1004, miss_cnt+1.
REQ-027 Write miss to dirty set, mem_req_ready held low 5 cycles -> mem_req_* stable 5 cycles, resp_valid on handshake cycle, c_waccess=1.
REQ-028 rst asserted in RD_WAIT, mem_resp_valid arrives 2 cycles later -> no resp_valid, no c_wvalid, FSM in IDLE, counters 0.
REQ-029 Stray mem_resp_valid in IDLE with req_valid=0 -> no outputs change.
